// File: rtl/fifo_dc_byte_packer.sv
// rtl/fifo_dc_byte_packer.sv - packs a byte stream little-endian into FIFO write words
// Optional frame/stall counters are built when FIFO_DC_BYTE_PACKER_STATS_EN is defined.
module fifo_dc_byte_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_w,
  input  logic                  rst_w,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  fifo_write,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_full,
  output logic                  busy
`ifdef FIFO_DC_BYTE_PACKER_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           stall_cnt
`endif
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0]      idx;
  logic                  pending;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  accept;
  logic                  complete;

  assign in_ready     = !pending || !fifo_full;
  assign fifo_write   = pending && !fifo_full;
  assign accept       = in_valid && in_ready;
  assign complete     = in_last || (idx == IDX_W'(BYTES - 1));
  assign fifo_data_in = word;
  assign busy         = pending || (idx != '0);

  // Lane 0 always opens a fresh word, so padding lanes are guaranteed zero.
  always_comb begin
    word_nxt = (idx == '0) ? '0 : word;
    word_nxt[8*idx +: 8] = in_data;
  end

  // A byte accepted while draining sets pending again, overriding the clear.
  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      idx     <= '0;
      pending <= 1'b0;
      word    <= '0;
    end else begin
      if (fifo_write)
        pending <= 1'b0;
      if (accept) begin
        word <= word_nxt;
        if (complete) begin
          pending <= 1'b1;
          idx     <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

`ifdef FIFO_DC_BYTE_PACKER_STATS_EN
  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && in_last)
        frame_cnt <= frame_cnt + 16'd1;
      if (pending && fifo_full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_dc_byte_packer.sv
// tb/tb_fifo_dc_byte_packer.sv - directed self-checking bench for fifo_dc_byte_packer
// Stats checks are compiled when FIFO_DC_BYTE_PACKER_STATS_EN is defined.
module tb_fifo_dc_byte_packer;
  localparam int DW = 32;

  logic          clk_w = 1'b0;
  logic          rst_w = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          fifo_write;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_full = 1'b0;
  logic          busy;
`ifdef FIFO_DC_BYTE_PACKER_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] wr_data[$];
  int            wr_cyc[$];

  fifo_dc_byte_packer #(.DATA_WIDTH(DW)) dut (
    .clk_w(clk_w),
    .rst_w(rst_w),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .fifo_write(fifo_write),
    .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full),
    .busy(busy)
`ifdef FIFO_DC_BYTE_PACKER_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk_w = ~clk_w;

  always @(posedge clk_w) cyc <= cyc + 1;

  // Log every write the FIFO would see, sampled mid-cycle.
  always @(negedge clk_w) begin
    if (fifo_write) begin
      wr_data.push_back(fifo_data_in);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst_w = 1'b1;
    tick();
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_write: got %b want 0", fifo_write); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_data_in !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", fifo_data_in); end
    rst_w = 1'b0;
    tick();
  endtask

  task automatic test_full_word();
    logic [7:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_data.delete(); wr_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = b[i]; in_last = (i == 3);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL word_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (fifo_write !== 1'b1) begin n_fail++; $display("FAIL word_write_latency: got %b want 1", fifo_write); end
    n_cmp++; if (fifo_data_in !== 32'h44332211) begin n_fail++; $display("FAIL word_data: got %h want 44332211", fifo_data_in); end
    tick();
    tick();
    n_cmp++; if (wr_data.size() !== 1) begin n_fail++; $display("FAIL word_count: got %0d want 1", wr_data.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL word_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_partial();
    wr_data.delete(); wr_cyc.delete();
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; tick();
    in_data = 8'hBB; in_last = 1'b1; tick();
    idle();
    tick(); tick();
    n_cmp++; if (wr_data.size() !== 1) begin n_fail++; $display("FAIL partial_count: got %0d want 1", wr_data.size()); end
    else begin
      n_cmp++; if (wr_data[0] !== 32'h0000BBAA) begin n_fail++; $display("FAIL partial_data: got %h want 0000bbaa", wr_data[0]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL partial_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    wr_data.delete(); wr_cyc.delete();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_last = (i == 8);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (wr_data.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", wr_data.size()); end
    else begin
      n_cmp++; if (wr_data[0] !== 32'h04030201) begin n_fail++; $display("FAIL b2b_word0: got %h want 04030201", wr_data[0]); end
      n_cmp++; if (wr_data[1] !== 32'h08070605) begin n_fail++; $display("FAIL b2b_word1: got %h want 08070605", wr_data[1]); end
      n_cmp++; if (wr_cyc[1] - wr_cyc[0] !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", wr_cyc[1] - wr_cyc[0]); end
    end
  endtask

  task automatic test_full_stall();
    logic [7:0] b[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    wr_data.delete(); wr_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = b[i]; in_last = 1'b0;
      if (i == 3) fifo_full = 1'b1;
      tick();
    end
    in_valid = 1'b1; in_data = 8'hB1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL stall_write[%0d]: got %b want 0", i, fifo_write); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (fifo_data_in !== 32'hA4A3A2A1) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want a4a3a2a1", i, fifo_data_in); end
      tick();
    end
    fifo_full = 1'b0;
    #1;
    n_cmp++; if (fifo_write !== 1'b1) begin n_fail++; $display("FAIL release_write: got %b want 1", fifo_write); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick();
    idle();
    #1;
    n_cmp++; if (fifo_write !== 1'b1) begin n_fail++; $display("FAIL release_next_write: got %b want 1", fifo_write); end
    n_cmp++; if (fifo_data_in !== 32'h000000B1) begin n_fail++; $display("FAIL release_next_data: got %h want 000000b1", fifo_data_in); end
    tick(); tick();
    n_cmp++; if (wr_data.size() !== 2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", wr_data.size()); end
    else begin
      n_cmp++; if (wr_data[0] !== 32'hA4A3A2A1) begin n_fail++; $display("FAIL stall_word0: got %h want a4a3a2a1", wr_data[0]); end
    end
  endtask

  task automatic test_reset_mid();
    wr_data.delete(); wr_cyc.delete();
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0; tick();
    in_data = 8'h66; tick();
    idle();
    #2 rst_w = 1'b1;
    #2 rst_w = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    tick();
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1; tick();
    idle();
    tick(); tick();
    n_cmp++; if (wr_data.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", wr_data.size()); end
    else begin
      n_cmp++; if (wr_data[0] !== 32'h00000077) begin n_fail++; $display("FAIL rstmid_data: got %h want 00000077", wr_data[0]); end
    end
  endtask

  task automatic test_idle_boundaries();
    wr_data.delete(); wr_cyc.delete();
    in_valid = 1'b0; in_last = 1'b1; in_data = 8'hEE;
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lastnovalid_busy: got %b want 0", busy); end
    in_valid = 1'b1; in_data = 8'hC1; in_last = 1'b0; tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b want 1", busy); end
    n_cmp++; if (wr_data.size() !== 0) begin n_fail++; $display("FAIL hold_nowrite: got %0d want 0", wr_data.size()); end
    in_valid = 1'b1; in_data = 8'hC2; in_last = 1'b1; tick();
    idle();
    tick(); tick();
    n_cmp++; if (wr_data.size() !== 1) begin n_fail++; $display("FAIL hold_count: got %0d want 1", wr_data.size()); end
    else begin
      n_cmp++; if (wr_data[0] !== 32'h0000C2C1) begin n_fail++; $display("FAIL hold_data: got %h want 0000c2c1", wr_data[0]); end
    end
  endtask

`ifdef FIFO_DC_BYTE_PACKER_STATS_EN
  task automatic test_stats();
    #2 rst_w = 1'b1;
    #2 rst_w = 1'b0;
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_reset_frame: got %0d want 0", frame_cnt); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i); in_last = 1'b1; tick();
      idle(); tick();
    end
    n_cmp++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL stats_frame: got %0d want 3", frame_cnt); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_stall_zero: got %0d want 0", stall_cnt); end
    in_valid = 1'b1; in_data = 8'h20; in_last = 1'b1; fifo_full = 1'b1; tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    fifo_full = 1'b0;
    n_cmp++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL stats_stall: got %0d want 4", stall_cnt); end
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_back_to_back();
    test_full_stall();
    test_reset_mid();
    test_idle_boundaries();
`ifdef FIFO_DC_BYTE_PACKER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_dc_byte_packer.md
Name: fifo_dc_byte_packer

Overview:
- Write-side feeder for the dual-clock FIFO, running entirely in the FIFO write domain.
- Accepts a byte stream with valid/ready/last and packs bytes little-endian into DATA_WIDTH words.
- A frame's final partial word is zero-padded and flushed.
- Drives the FIFO write port directly and honours its full flag; no data is ever written while full.

Parameters:
- DATA_WIDTH, 32, FIFO word width. Must be a multiple of 8 and at least 8.
- BYTES (localparam), DATA_WIDTH/8, lanes per word.
- IDX_W (localparam), max(1, clog2(BYTES)), lane index width.

Ports:
- clk_w  in  1  write-domain clock.
- rst_w  in  1  reset, asynchronous, active-high.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  byte payload.
- in_last  in  1  byte is last of frame; qualified by in_valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- fifo_write  out  1  write strobe to FIFO.
- fifo_data_in  out  DATA_WIDTH  word to FIFO.
- fifo_full  in  1  FIFO full flag, registered in the clk_w domain.
- busy  out  1  partial or pending word held.

Behaviour:
- Reset (async, rst_w=1):
  - idx=0, pending=0, word=0, fifo_data_in=0, busy=0.
  - fifo_write=0, in_ready=1.
  - Any partial word in flight is discarded.
- State: FILL (pending=0) / HOLD (pending=1).
- Handshake:
  - in_ready = !pending || !fifo_full (combinational).
  - fifo_write = pending && !fifo_full (combinational).
  - fifo_data_in = word register; stable while pending.
- FILL, byte accepted:
  - word[8*idx +: 8] <= in_data.
  - If idx==BYTES-1 or in_last: pending<=1, idx<=0. Lanes above idx in the completed word read 0.
  - Otherwise idx<=idx+1.
- HOLD, fifo_full=1:
  - Hold word; no write; in_ready=0.
- HOLD, fifo_full=0:
  - fifo_write=1 this cycle; pending<=0.
  - If a byte is accepted in the same cycle, it loads lane 0 of a fresh word, with the other lanes cleared.
  - If that byte also completes the word (BYTES==1 or in_last), pending stays 1.
  - This gives one word per BYTES cycles sustained, with no bubble.
- Zero padding: every new word starts with all lanes cleared, so padding is always 0x00.
- Latency: fifo_write asserts the cycle after the completing byte is accepted, provided fifo_full=0.
- Boundaries:
  - in_last on lane BYTES-1 produces no extra empty word.
  - in_valid=0 mid-word holds idx indefinitely; there is no timeout.
  - A frame of one byte produces one word: data in lane 0, rest zero.
  - in_last with in_valid=0 is ignored.
  - When fifo_full deasserts, at most one write is issued per cycle.
- busy = pending || (idx!=0).

Optional Feature:
- Macro: FIFO_DC_BYTE_PACKER_STATS_EN.
- With the macro defined, extra outputs are added:
  - frame_cnt[15:0]: increments on each accepted byte with in_last=1; wraps 0xFFFF->0.
  - stall_cnt[15:0]: increments each cycle pending && fifo_full; saturates at 0xFFFF.
  - Both reset to 0 on rst_w.
- Without the macro: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- DATA_WIDTH=32, fifo_full=0, bytes 0x11,0x22,0x33,0x44 (last on 0x44) back-to-back -> one write, fifo_data_in=0x44332211, the cycle after 0x44 is accepted; in_ready stays 1.
- Frame 0xAA,0xBB (last) -> one write of 0x0000BBAA; busy=0 afterwards.
- 8 bytes 0x01..0x08 continuous, last on 0x08 -> writes 0x04030201 then 0x08070605, no idle cycle between them, no third word.
- Word complete with fifo_full=1 held 5 cycles -> fifo_write=0 and in_ready=0 for 5 cycles, word unchanged; on full=0, a single write occurs and a byte presented that cycle is accepted into lane 0.
- rst_w pulsed mid-word after 0x55,0x66 -> no write; the next frame 0x77 (last) writes 0x00000077.
- With STATS_EN: 3 frames -> frame_cnt=3; 4 stalled cycles -> stall_cnt=4.
